i2s_rx_sequencer: RTL and testbench
===================================

# i2s_rx_sequencer

Master-mode I2S receive controller: generates the bit clock and word select toward the codec, samples the serial data line, and assembles each left/right 24-bit sample pair. It delivers each pair to downstream logic over a valid/ready handshake. It sits between the codec pins and the audio sample consumer, and replaces the free-running deserializer with a sequenced, flow-controlled path.

## Interface
- CLK_DIV, 4, system clk cycles per sck half-period; legal range 1 and up.
- DATA_W, 24, bits per sample.
- SLOT_W, 32, sck cycles per channel slot; must be at least DATA_W+1.

- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  level; start/stop request.
- sd  in  1  serial data from codec (already synchronised).
- sck  out  1  I2S bit clock.
- ws  out  1  word select; 0 = left slot, 1 = right slot.
- left_data  out  DATA_W  last delivered left sample.
- right_data  out  DATA_W  last delivered right sample.
- frame_valid  out  1  a sample pair is held for the consumer.
- frame_ready  in  1  the consumer accepts the pair.
- overrun  out  1  sticky flag; a completed frame was dropped.
- clear_ovr  in  1  single-cycle pulse; clears overrun (and ovr_count).
- busy  out  1  high in RUN and DRAIN states.
- ovr_count  out  16  dropped-frame count; present only with the macro enabled.

## Operation
- States:
  - IDLE: sck held 0, ws held 1, counters zero.
  - RUN: normal capture.
  - DRAIN: finish the current frame.
- Transitions:
  - IDLE→RUN when enable=1.
  - RUN→DRAIN when enable=0.
  - DRAIN→RUN if enable returns to 1 before the frame boundary.
  - DRAIN→IDLE at the frame boundary.
- Frame boundary: the fall tick that wraps bit_cnt while ws=1.
- Divider: div_cnt counts 0..CLK_DIV-1. Each wrap toggles sck and produces a rise tick or fall tick strobe.
- On entering RUN: bit_cnt=SLOT_W-1, ws=1.
- Fall tick:
  - If bit_cnt=SLOT_W-1, bit_cnt wraps to 0 and ws toggles.
  - Otherwise bit_cnt increments.
- Rise tick: sd is sampled.
  - Slot position 0 is the I2S one-bit delay and is ignored.
  - Positions 1..DATA_W shift in MSB first.
  - Positions above DATA_W are ignored.
- Frame completion is the rise tick at right-slot position DATA_W.
  - If frame_valid=0, or frame_valid=1 with frame_ready=1 in the same cycle: load left_data/right_data and set frame_valid.
  - Otherwise the new pair is dropped, outputs are unchanged, and overrun is set.
- Handshake:
  - frame_valid falls on the cycle after frame_valid&frame_ready, unless a new frame loads in that same cycle.
  - Data is stable while frame_valid=1.
  - The handshake is independent of state; a pending frame survives into IDLE.
- Same-cycle overrun set and clear_ovr: set wins.

## Timing
- Reset values:
  - sck=0, ws=1, busy=0.
  - left_data=0, right_data=0.
  - frame_valid=0, overrun=0, ovr_count=0.
  - State IDLE.
- Reset mid-frame: the partial frame is discarded and no frame_valid is produced.
- sck period is 2*CLK_DIV clk cycles.
- First sck rise occurs CLK_DIV cycles after enable is registered in RUN. The first fall, at 2*CLK_DIV, starts the left slot (ws→0).
- frame_valid asserts 1 clk after the completing rise tick.
- busy drops on the clk after the DRAIN→IDLE fall tick; sck stays low from that point on.

## Configuration
- I2S_RX_OVR_COUNT_EN defined:
  - ovr_count port present.
  - Increments on each dropped frame and saturates at 0xFFFF.
  - clear_ovr zeroes it.
- I2S_RX_OVR_COUNT_EN undefined: the port and counter are absent; overrun behaves identically.

## Structure
- Package i2s_pkg holds:
  - the state enum (IDLE, RUN, DRAIN);
  - the default DATA_W and SLOT_W constants;
  - the ovr_count width.
- Sub-module i2s_clk_gen contains the divider. It outputs sck, rise_tick and fall_tick, with run as its input.
- Slot counting, shifting and the handshake stay in the top module.

## Test plan
All scenarios use CLK_DIV=2, SLOT_W=32, DATA_W=24.
- Reset: assert rst_n=0 → sck=0, ws=1, frame_valid=0, overrun=0, busy=0, ovr_count=0.
- Single frame: enable=1, codec model drives left 0xA5A5A5 and right 0x123456, frame_ready=1 → sck period 4 clk, ws toggles every 32 sck. frame_valid pulses with left_data=0xA5A5A5 and right_data=0x123456, 1 clk after the right LSB rise tick.
- Backpressure: frame_ready=0 across two frames → first pair is held, overrun=1, ovr_count=1. A clear_ovr pulse then gives overrun=0 and ovr_count=0.
- Simultaneous accept: frame_ready=1 exactly on the completion cycle with frame_valid=1 → new pair loads, frame_valid stays 1, overrun stays 0.
- Stop: enable→0 at left-slot bit 5 → frame completes and frame_valid asserts with correct data, state returns to IDLE, sck held 0, ws=1, busy=0.
- Mid-frame reset: rst_n low at right-slot bit 10 → all outputs reach reset values immediately, no frame_valid. After release with enable=1, the next full frame is captured correctly.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S receive sequencer.
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int DEF_DATA_W = 24;
  localparam int DEF_SLOT_W = 32;
  localparam int OVR_CNT_W  = 16;

  // Saturating increment for the dropped-frame counter.
  function automatic logic [OVR_CNT_W-1:0] sat_inc(input logic [OVR_CNT_W-1:0] v);
    if (v == {OVR_CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(OVR_CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// Bit-clock divider: toggles sck every CLK_DIV clk cycles while run is high and
// flags the cycle in which each sck edge will happen.
module i2s_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic sck,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_r;
  logic             sck_r;
  logic             wrap_s;

  // Strobes are decoded from registers only, so they are glitch-free.
  always_comb begin
    wrap_s = run && (div_cnt_r == DIV_LAST);
  end

  assign sck       = sck_r;
  assign rise_tick = wrap_s & ~sck_r;
  assign fall_tick = wrap_s & sck_r;

  // Half-period divider; idles with sck low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_r <= {DIV_W{1'b0}};
      sck_r     <= 1'b0;
    end else if (!run) begin
      div_cnt_r <= {DIV_W{1'b0}};
      sck_r     <= 1'b0;
    end else if (wrap_s) begin
      div_cnt_r <= {DIV_W{1'b0}};
      sck_r     <= ~sck_r;
    end else begin
      div_cnt_r <= div_cnt_r + DIV_W'(1);
    end
  end

endmodule

// File: rtl/i2s_rx_sequencer.sv
// Master-mode I2S receiver with valid/ready sample-pair delivery.
// Define I2S_RX_OVR_COUNT_EN to add the saturating ovr_count port.
module i2s_rx_sequencer
  import i2s_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int SLOT_W  = DEF_SLOT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              sd,
  output logic              sck,
  output logic              ws,
  output logic [DATA_W-1:0] left_data,
  output logic [DATA_W-1:0] right_data,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic              overrun,
  input  logic              clear_ovr,
  output logic              busy
`ifdef I2S_RX_OVR_COUNT_EN
  ,
  output logic [OVR_CNT_W-1:0] ovr_count
`endif
);

  localparam int BIT_W = $clog2(SLOT_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(SLOT_W - 1);
  localparam logic [BIT_W-1:0] DATA_POS = BIT_W'(DATA_W);

  state_e            state_r;
  logic [BIT_W-1:0]  bit_cnt_r;
  logic              ws_r;
  logic              busy_r;
  logic [DATA_W-1:0] shift_r;
  logic [DATA_W-1:0] left_hold_r;
  logic [DATA_W-1:0] left_r;
  logic [DATA_W-1:0] right_r;
  logic              valid_r;
  logic              ovr_r;

  logic              run_s;
  logic              sck_s;
  logic              rise_tick_s;
  logic              fall_tick_s;
  logic              slot_end_s;
  logic              boundary_s;
  logic [BIT_W-1:0]  bit_nxt_s;
  logic              ws_nxt_s;
  logic [DATA_W-1:0] sample_s;
  logic              shift_en_s;
  logic              complete_s;
  logic              accept_s;
  logic              drop_s;

  assign run_s = (state_r != IDLE);

  i2s_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run_s),
    .sck       (sck_s),
    .rise_tick (rise_tick_s),
    .fall_tick (fall_tick_s)
  );

  // Slot position bookkeeping and capture/handshake decode.
  always_comb begin
    slot_end_s = fall_tick_s && (bit_cnt_r == LAST_BIT);
    boundary_s = slot_end_s && ws_r;
    if (slot_end_s) begin
      bit_nxt_s = {BIT_W{1'b0}};
      ws_nxt_s  = ~ws_r;
    end else if (fall_tick_s) begin
      bit_nxt_s = bit_cnt_r + BIT_W'(1);
      ws_nxt_s  = ws_r;
    end else begin
      bit_nxt_s = bit_cnt_r;
      ws_nxt_s  = ws_r;
    end
    // Position 0 is the one-bit I2S delay; only 1..DATA_W carry data.
    sample_s   = {shift_r[DATA_W-2:0], sd};
    shift_en_s = rise_tick_s && (bit_cnt_r >= BIT_W'(1)) && (bit_cnt_r <= DATA_POS);
    complete_s = rise_tick_s && ws_r && (bit_cnt_r == DATA_POS);
    accept_s   = complete_s && (!valid_r || frame_ready);
    drop_s     = complete_s && !accept_s;
  end

  // Sequencer FSM with registered ws and busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      bit_cnt_r <= {BIT_W{1'b0}};
      ws_r      <= 1'b1;
      busy_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          ws_r   <= 1'b1;
          busy_r <= enable;
          if (enable) begin
            state_r   <= RUN;
            bit_cnt_r <= LAST_BIT;
          end else begin
            bit_cnt_r <= {BIT_W{1'b0}};
          end
        end
        RUN: begin
          busy_r    <= 1'b1;
          bit_cnt_r <= bit_nxt_s;
          ws_r      <= ws_nxt_s;
          if (!enable) begin
            state_r <= DRAIN;
          end
        end
        DRAIN: begin
          if (!enable && boundary_s) begin
            state_r   <= IDLE;
            bit_cnt_r <= {BIT_W{1'b0}};
            ws_r      <= 1'b1;
            busy_r    <= 1'b0;
          end else begin
            state_r   <= enable ? RUN : DRAIN;
            bit_cnt_r <= bit_nxt_s;
            ws_r      <= ws_nxt_s;
            busy_r    <= 1'b1;
          end
        end
        default: begin
          state_r   <= IDLE;
          bit_cnt_r <= {BIT_W{1'b0}};
          ws_r      <= 1'b1;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  // Serial shift register; the left word is parked until the right word completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r     <= {DATA_W{1'b0}};
      left_hold_r <= {DATA_W{1'b0}};
    end else begin
      if (shift_en_s) begin
        shift_r <= sample_s;
      end
      if (shift_en_s && !ws_r && (bit_cnt_r == DATA_POS)) begin
        left_hold_r <= sample_s;
      end
    end
  end

  // Output holding registers, valid/ready handshake and sticky overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left_r  <= {DATA_W{1'b0}};
      right_r <= {DATA_W{1'b0}};
      valid_r <= 1'b0;
      ovr_r   <= 1'b0;
    end else begin
      if (accept_s) begin
        left_r  <= left_hold_r;
        right_r <= sample_s;
        valid_r <= 1'b1;
      end else if (valid_r && frame_ready) begin
        valid_r <= 1'b0;
      end
      if (drop_s) begin
        ovr_r <= 1'b1;
      end else if (clear_ovr) begin
        ovr_r <= 1'b0;
      end
    end
  end

`ifdef I2S_RX_OVR_COUNT_EN
  logic [OVR_CNT_W-1:0] ovr_cnt_r;

  // Dropped-frame counter, saturating; a drop outranks a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_cnt_r <= {OVR_CNT_W{1'b0}};
    end else if (drop_s) begin
      ovr_cnt_r <= sat_inc(ovr_cnt_r);
    end else if (clear_ovr) begin
      ovr_cnt_r <= {OVR_CNT_W{1'b0}};
    end
  end

  assign ovr_count = ovr_cnt_r;
`endif

  assign sck         = sck_s;
  assign ws          = ws_r;
  assign busy        = busy_r;
  assign left_data   = left_r;
  assign right_data  = right_r;
  assign frame_valid = valid_r;
  assign overrun     = ovr_r;

endmodule

// File: tb/tb_i2s_rx_sequencer.sv
// Directed bench for i2s_rx_sequencer with a simple I2S codec model.
module tb_i2s_rx_sequencer;

  localparam int CLK_DIV = 2;
  localparam int DATA_W  = 24;
  localparam int SLOT_W  = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic              sd = 1'b0;
  logic              frame_ready;
  logic              clear_ovr;
  logic              sck;
  logic              ws;
  logic [DATA_W-1:0] left_data;
  logic [DATA_W-1:0] right_data;
  logic              frame_valid;
  logic              overrun;
  logic              busy;
`ifdef I2S_RX_OVR_COUNT_EN
  logic [15:0]       ovr_count;
`endif

  int checks = 0;
  int errors = 0;

  logic [23:0] codec_left  = 24'h0;
  logic [23:0] codec_right = 24'h0;
  logic        sck_prev    = 1'b0;
  logic        ws_prev     = 1'b1;
  int          pos         = 100;

  always #5 clk = ~clk;

  i2s_rx_sequencer #(
    .CLK_DIV (CLK_DIV),
    .DATA_W  (DATA_W),
    .SLOT_W  (SLOT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .sd          (sd),
    .sck         (sck),
    .ws          (ws),
    .left_data   (left_data),
    .right_data  (right_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .overrun     (overrun),
    .clear_ovr   (clear_ovr),
    .busy        (busy)
`ifdef I2S_RX_OVR_COUNT_EN
    ,
    .ovr_count   (ovr_count)
`endif
  );

  // Codec: shifts a new bit out after each sck fall, MSB one bit after ws changes.
  always @(negedge clk) begin
    if (sck_prev && !sck) begin
      if (ws != ws_prev) pos = 0;
      else pos = pos + 1;
      ws_prev = ws;
    end
    sck_prev = sck;
    if (pos >= 1 && pos <= 24) sd = ws ? codec_right[24-pos] : codec_left[24-pos];
    else sd = 1'b0;
  end

  task automatic wait_ws_rise(output bit ok);
    int n = 0;
    while (ws !== 1'b0 && n < 600) begin @(negedge clk); n++; end
    while (ws !== 1'b1 && n < 600) begin @(negedge clk); n++; end
    ok = (n < 600);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; enable = 1'b0; frame_ready = 1'b0; clear_ovr = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (sck !== 1'b0) begin errors++; $display("FAIL reset_sck got %b want 0", sck); end
    checks++; if (ws !== 1'b1) begin errors++; $display("FAIL reset_ws got %b want 1", ws); end
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", frame_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (left_data !== 24'h0 || right_data !== 24'h0) begin errors++; $display("FAIL reset_data got %h/%h want 0/0", left_data, right_data); end
`ifdef I2S_RX_OVR_COUNT_EN
    checks++; if (ovr_count !== 16'h0) begin errors++; $display("FAIL reset_ovr_count got %h want 0", ovr_count); end
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0 || sck !== 1'b0) begin errors++; $display("FAIL idle_hold got busy=%b sck=%b want 0/0", busy, sck); end
  endtask

  task automatic test_single_frame;
    int n;
    int fv_at;
    bit ok;
    logic [23:0] got_l, got_r;
    logic fv_after;
    codec_left = 24'hA5A5A5; codec_right = 24'h123456; frame_ready = 1'b1; enable = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (sck !== 1'b1 && n < 50);
    checks++; if (n != 3) begin errors++; $display("FAIL first_rise got %0d want 3 samples", n); end
    n = 0;
    while (sck === 1'b1 && n < 50) begin @(negedge clk); n++; end
    while (sck === 1'b0 && n < 50) begin @(negedge clk); n++; end
    checks++; if (n != 4) begin errors++; $display("FAIL sck_period got %0d want 4", n); end
    wait_ws_rise(ok);
    checks++; if (!ok) begin errors++; $display("FAIL ws_rise_timeout got 0 want 1"); end
    n = 0; fv_at = -1; got_l = 24'h0; got_r = 24'h0; fv_after = 1'bx;
    while (ws === 1'b1 && n < 300) begin
      @(negedge clk); n++;
      if (fv_at >= 0 && n == fv_at + 1) fv_after = frame_valid;
      if (frame_valid === 1'b1 && fv_at < 0) begin fv_at = n; got_l = left_data; got_r = right_data; end
    end
    checks++; if (n != 128) begin errors++; $display("FAIL ws_slot_len got %0d want 128", n); end
    checks++; if (fv_at != 98) begin errors++; $display("FAIL valid_latency got %0d want 98", fv_at); end
    checks++; if (got_l !== 24'hA5A5A5) begin errors++; $display("FAIL single_left got %h want a5a5a5", got_l); end
    checks++; if (got_r !== 24'h123456) begin errors++; $display("FAIL single_right got %h want 123456", got_r); end
    checks++; if (fv_after !== 1'b0) begin errors++; $display("FAIL valid_pulse got %b want 0", fv_after); end
  endtask

  task automatic test_backpressure;
    int n;
    frame_ready = 1'b0; codec_left = 24'h111111; codec_right = 24'h222222;
    n = 0;
    while (frame_valid !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    checks++; if (n >= 400) begin errors++; $display("FAIL bp_first_timeout got %0d want <400", n); end
    codec_left = 24'h333333; codec_right = 24'h444444;
    n = 0;
    while (overrun !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    checks++; if (n >= 400) begin errors++; $display("FAIL bp_overrun_timeout got %0d want <400", n); end
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b want 1", frame_valid); end
    checks++; if (left_data !== 24'h111111 || right_data !== 24'h222222) begin errors++; $display("FAIL bp_held got %h/%h want 111111/222222", left_data, right_data); end
`ifdef I2S_RX_OVR_COUNT_EN
    checks++; if (ovr_count !== 16'd1) begin errors++; $display("FAIL bp_ovr_count got %0d want 1", ovr_count); end
`endif
    clear_ovr = 1'b1;
    @(negedge clk);
    clear_ovr = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL clear_overrun got %b want 0", overrun); end
`ifdef I2S_RX_OVR_COUNT_EN
    checks++; if (ovr_count !== 16'd0) begin errors++; $display("FAIL clear_ovr_count got %0d want 0", ovr_count); end
`endif
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL clear_keeps_valid got %b want 1", frame_valid); end
  endtask

  task automatic test_simultaneous_accept;
    bit ok;
    codec_left = 24'h0ABCDE; codec_right = 24'hFEDCBA;
    wait_ws_rise(ok);
    checks++; if (!ok) begin errors++; $display("FAIL sim_ws_timeout got 0 want 1"); end
    repeat (97) @(negedge clk);
    checks++; if (frame_valid !== 1'b1 || left_data !== 24'h111111) begin errors++; $display("FAIL sim_pre got %b/%h want 1/111111", frame_valid, left_data); end
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL sim_valid got %b want 1", frame_valid); end
    checks++; if (left_data !== 24'h0ABCDE || right_data !== 24'hFEDCBA) begin errors++; $display("FAIL sim_data got %h/%h want 0abcde/fedcba", left_data, right_data); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL sim_overrun got %b want 0", overrun); end
    @(negedge clk);
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL sim_hold got %b want 1", frame_valid); end
  endtask

  task automatic test_stop;
    int n;
    int highs;
    frame_ready = 1'b1; codec_left = 24'h5A5A5A; codec_right = 24'h00F00F;
    n = 0;
    while (ws !== 1'b0 && n < 400) begin @(negedge clk); n++; end
    repeat (21) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drain_busy got %b want 1", busy); end
    n = 0;
    while (frame_valid !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    checks++; if (n >= 400) begin errors++; $display("FAIL stop_valid_timeout got %0d want <400", n); end
    checks++; if (left_data !== 24'h5A5A5A || right_data !== 24'h00F00F) begin errors++; $display("FAIL stop_data got %h/%h want 5a5a5a/00f00f", left_data, right_data); end
    n = 0;
    while (busy !== 1'b0 && n < 200) begin @(negedge clk); n++; end
    checks++; if (n >= 200) begin errors++; $display("FAIL stop_idle_timeout got %0d want <200", n); end
    checks++; if (sck !== 1'b0 || ws !== 1'b1) begin errors++; $display("FAIL stop_pins got sck=%b ws=%b want 0/1", sck, ws); end
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL stop_acked got %b want 0", frame_valid); end
    highs = 0;
    repeat (20) begin @(negedge clk); if (sck !== 1'b0 || busy !== 1'b0) highs++; end
    checks++; if (highs != 0) begin errors++; $display("FAIL idle_quiet got %0d want 0", highs); end
  endtask

  task automatic test_mid_reset;
    int n;
    int seen;
    bit ok;
    codec_left = 24'h777777; codec_right = 24'h888888; frame_ready = 1'b1; enable = 1'b1;
    wait_ws_rise(ok);
    checks++; if (!ok) begin errors++; $display("FAIL mr_ws_timeout got 0 want 1"); end
    repeat (42) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (sck !== 1'b0 || ws !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL mr_pins got sck=%b ws=%b busy=%b want 0/1/0", sck, ws, busy); end
    checks++; if (frame_valid !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL mr_flags got %b/%b want 0/0", frame_valid, overrun); end
    checks++; if (left_data !== 24'h0 || right_data !== 24'h0) begin errors++; $display("FAIL mr_data got %h/%h want 0/0", left_data, right_data); end
    codec_left = 24'h13579B; codec_right = 24'h2468AC;
    seen = 0;
    repeat (5) begin @(negedge clk); if (frame_valid !== 1'b0) seen++; end
    rst_n = 1'b1;
    n = 0;
    while (frame_valid !== 1'b1 && n < 400) begin @(negedge clk); n++; if (n < 200 && frame_valid === 1'b1) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL mr_no_partial got %0d want 0", seen); end
    checks++; if (n >= 400) begin errors++; $display("FAIL mr_valid_timeout got %0d want <400", n); end
    checks++; if (left_data !== 24'h13579B || right_data !== 24'h2468AC) begin errors++; $display("FAIL mr_data_after got %h/%h want 13579b/2468ac", left_data, right_data); end
  endtask

  initial begin
    test_reset;
    test_single_frame;
    test_backpressure;
    test_simultaneous_accept;
    test_stop;
    test_mid_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
